// File: rtl/dcim_pkg.sv
// dcim_pkg: shared defaults, accumulator state encoding and saturation helper
package dcim_pkg;
  localparam int DEF_GIO_OUT_WIDTH = 27;
  localparam int DEF_IN_BITS = 8;
  localparam int DEF_RES_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;
  // {above max, below min} for a signed value against a signed rw-bit range
  function automatic logic [1:0] sat_dir(input logic signed [63:0] v, input int rw);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (rw - 1);
    return {v >= lim, v < -lim};
  endfunction
endpackage

// File: rtl/shift_accumulator_if.sv
// shift_accumulator_if: psum beat input and result output handshake bundle
interface shift_accumulator_if #(
  parameter int GIO_OUT_WIDTH = dcim_pkg::DEF_GIO_OUT_WIDTH,
  parameter int RES_WIDTH = dcim_pkg::DEF_RES_WIDTH
);
  logic [GIO_OUT_WIDTH-1:0] psum_in;
  logic psum_valid;
  logic psum_ready;
  logic act_signed;
  logic [RES_WIDTH-1:0] res_out;
  logic res_valid;
  logic res_ready;
  logic busy;
`ifdef ACC_SAT_EN
  logic sat_flag;
  modport master(output psum_in, psum_valid, act_signed, res_ready,
                 input psum_ready, res_out, res_valid, busy, sat_flag);
  modport slave(input psum_in, psum_valid, act_signed, res_ready,
                output psum_ready, res_out, res_valid, busy, sat_flag);
`else
  modport master(output psum_in, psum_valid, act_signed, res_ready,
                 input psum_ready, res_out, res_valid, busy);
  modport slave(input psum_in, psum_valid, act_signed, res_ready,
                output psum_ready, res_out, res_valid, busy);
`endif
endinterface

// File: rtl/acc_saturate.sv
// acc_saturate: clip a signed accumulator to the signed result range and flag clipping
module acc_saturate
  import dcim_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_GIO_OUT_WIDTH + DEF_IN_BITS,
  parameter int RES_WIDTH = DEF_RES_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic [RES_WIDTH-1:0] o_res,
  output logic o_sat
);
  logic [1:0] w_dir;
  assign w_dir = sat_dir(64'(i_acc), RES_WIDTH);
  assign o_res = w_dir[1] ? {1'b0, {(RES_WIDTH-1){1'b1}}}
               : w_dir[0] ? {1'b1, {(RES_WIDTH-1){1'b0}}}
               : i_acc[RES_WIDTH-1:0];
  assign o_sat = |w_dir;
endmodule

// File: rtl/shift_accumulator.sv
// shift_accumulator: MSB-first bit-serial shift-and-add of psum beats into a dot-product result
// ACC_SAT_EN: saturate res_out to RES_WIDTH and add sat_flag; otherwise res_out wraps
module shift_accumulator
  import dcim_pkg::*;
#(
  parameter int GIO_OUT_WIDTH = DEF_GIO_OUT_WIDTH,
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int ACC_WIDTH = GIO_OUT_WIDTH + IN_BITS,
  parameter int RES_WIDTH = DEF_RES_WIDTH
) (
  input logic clk,
  input logic rst,
  shift_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(IN_BITS + 1);
  acc_state_t r_state, w_next;
  logic signed [ACC_WIDTH-1:0] r_acc, w_ext;
  logic [CNT_W-1:0] r_beat_cnt;
  logic w_fire, w_last;
  assign w_ext = ACC_WIDTH'($signed(bus.psum_in));
  assign w_fire = bus.psum_valid && bus.psum_ready;
  assign w_last = r_beat_cnt == CNT_W'(IN_BITS - 1);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (w_fire ? ACCUM : IDLE)
           : r_state == ACCUM ? (w_fire && w_last ? HOLD : ACCUM)
           : (bus.res_ready ? IDLE : HOLD);
  end
  // the first (MSB) beat carries negative weight for signed activations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == HOLD && bus.res_ready) begin
        r_acc <= '0;
        r_beat_cnt <= '0;
      end else if (w_fire) begin
        r_acc <= r_state == IDLE ? (bus.act_signed ? -w_ext : w_ext) : (r_acc <<< 1) + w_ext;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end
  assign bus.psum_ready = r_state != HOLD;
  assign bus.res_valid = r_state == HOLD;
  assign bus.busy = r_state != IDLE;
`ifdef ACC_SAT_EN
  logic w_sat;
  acc_saturate #(.ACC_WIDTH(ACC_WIDTH), .RES_WIDTH(RES_WIDTH)) u_sat (
    .i_acc(r_acc),
    .o_res(bus.res_out),
    .o_sat(w_sat)
  );
  assign bus.sat_flag = w_sat && bus.res_valid;
`else
  assign bus.res_out = r_acc[RES_WIDTH-1:0];
`endif
endmodule

// File: tb/tb_shift_accumulator.sv
// tb_shift_accumulator: randomized scoreboard bench against a weighted-sum reference model
module tb_shift_accumulator;
  localparam int GW = 27;
  localparam int N = 8;
  localparam int RW = 32;
  localparam longint HI = (longint'(1) <<< (RW - 1)) - 1;
  localparam longint LO = -HI - 1;
  typedef struct packed {logic [RW-1:0] res; logic sat;} exp_t;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs = -1;
  exp_t q[$];
  exp_t m_e;
  logic m_stall = 0;
  logic [RW-1:0] m_prev = '0;
  logic m_sat;
  shift_accumulator_if #(.GIO_OUT_WIDTH(GW), .RES_WIDTH(RW)) sa_if ();
  shift_accumulator #(.GIO_OUT_WIDTH(GW), .IN_BITS(N), .RES_WIDTH(RW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(sa_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
`ifdef ACC_SAT_EN
  assign m_sat = sa_if.sat_flag;
`else
  assign m_sat = 1'b0;
`endif
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // result = sum of psum_i * 2^(N-1-i), MSB term negated for signed activations
  function automatic exp_t model(input logic sgn, input logic [GW-1:0] v[N]);
    longint s;
    longint p;
    logic [63:0] t;
    exp_t e;
    s = 0;
    for (int i = 0; i < N; i++) begin
      p = longint'($signed(v[i])) <<< (N - 1 - i);
      s += (sgn && i == 0) ? -p : p;
    end
    t = s;
`ifdef ACC_SAT_EN
    e.sat = (s > HI) || (s < LO);
    e.res = s > HI ? {1'b0, {(RW-1){1'b1}}} : s < LO ? {1'b1, {(RW-1){1'b0}}} : t[RW-1:0];
`else
    e.sat = 1'b0;
    e.res = t[RW-1:0];
`endif
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst) m_stall = 0;
    else begin
      if (m_stall && sa_if.res_valid) chk("res_stable", sa_if.res_out, m_prev);
      if (sa_if.res_valid) chk("psum_ready_in_hold", sa_if.psum_ready, 0);
      if (sa_if.res_valid && sa_if.res_ready) begin
        last_hs = cyc + 1;
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          m_e = q.pop_front();
          chk("res_out", sa_if.res_out, m_e.res);
          chk("sat_flag", m_sat, m_e.sat);
        end
      end
      m_stall = sa_if.res_valid && !sa_if.res_ready;
      m_prev = sa_if.res_out;
    end
  end
  task automatic send_op(input logic sgn, input logic [GW-1:0] v[N], input int nb, input int gmax,
                         output int first);
    int n;
    first = -1;
    if (nb == N) q.push_back(model(sgn, v));
    for (int i = 0; i < nb; i++) begin
      sa_if.psum_valid = 1;
      sa_if.psum_in = v[i];
      sa_if.act_signed = (i == 0) ? sgn : 1'($urandom);
      n = 0;
      while (!sa_if.psum_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk("beat_ready_wait", sa_if.psum_ready, 1);
      @(posedge clk); #1;
      if (i == 0) first = cyc;
      sa_if.psum_valid = 0;
      if (i < nb - 1) repeat ($urandom_range(0, gmax)) begin
        @(posedge clk); #1;
      end
    end
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (sa_if.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", sa_if.busy, 0);
  endtask
  initial begin
    logic [GW-1:0] v[N];
    logic [GW-1:0] vv[N];
    logic sg;
    int fc;
    sa_if.psum_valid = 0;
    sa_if.psum_in = '0;
    sa_if.act_signed = 0;
    sa_if.res_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_res_valid", sa_if.res_valid, 0);
    chk("rst_psum_ready", sa_if.psum_ready, 1);
    chk("rst_busy", sa_if.busy, 0);
    chk("rst_res_out", sa_if.res_out, 0);
    @(posedge clk); #1;
    foreach (v[i]) v[i] = 1;
    send_op(0, v, N, 0, fc);
    chk("latency_unsigned", sa_if.res_valid, 1);
    wait_idle();
    send_op(1, v, N, 0, fc);
    wait_idle();
    foreach (v[i]) v[i] = -27'sd3;
    send_op(1, v, N, 0, fc);
    chk("latency_signed", sa_if.res_valid, 1);
    wait_idle();
    foreach (vv[i]) vv[i] = GW'($urandom);
    sg = 1'($urandom);
    send_op(sg, vv, N, 0, fc);
    wait_idle();
    sa_if.res_ready = 0;
    send_op(sg, vv, N, 3, fc);
    chk("latency_gapped", sa_if.res_valid, 1);
    sa_if.psum_valid = 1;
    sa_if.psum_in = GW'($urandom);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("hold_busy", sa_if.busy, 1);
    chk("hold_valid", sa_if.res_valid, 1);
    sa_if.psum_valid = 0;
    sa_if.res_ready = 1;
    @(posedge clk); #1;
    chk("hold_beat_not_taken", sa_if.busy, 0);
    foreach (v[i]) v[i] = GW'($urandom);
    send_op(0, v, 4, 1, fc);
    rst = 1;
    #1;
    chk("midrst_busy", sa_if.busy, 0);
    chk("midrst_res_valid", sa_if.res_valid, 0);
    chk("midrst_psum_ready", sa_if.psum_ready, 1);
    chk("midrst_res_out", sa_if.res_out, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    send_op(0, v, N, 1, fc);
    wait_idle();
    foreach (v[i]) v[i] = 27'h3FFFFFF;
    send_op(0, v, N, 0, fc);
    wait_idle();
    foreach (v[i]) v[i] = GW'($urandom);
    send_op(1, v, N, 0, fc);
    foreach (vv[i]) vv[i] = GW'($urandom);
    send_op(0, vv, N, 0, fc);
    chk("b2b_first_beat", fc, last_hs + 1);
    wait_idle();
    for (int k = 0; k < 20; k++) begin
      foreach (v[i]) v[i] = k[0] ? GW'($urandom) : GW'($urandom_range(0, 15)) - GW'(8);
      sa_if.res_ready = 1'($urandom);
      send_op(1'($urandom), v, N, 2, fc);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      sa_if.res_ready = 1;
      wait_idle();
    end
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
